// File: rtl/mem_bus_pkg.sv
// Shared definitions for the KS-10 memory/IO bus initiator: flag bit
// positions inside the bus address word, address field bounds, FSM states
// and a helper that assembles the address word.
package mem_bus_pkg;

   localparam int FLAG_READ  = 3;
   localparam int FLAG_RPW   = 4;
   localparam int FLAG_WRITE = 5;
   localparam int FLAG_IO    = 10;

   localparam int ADDR_LO    = 14;
   localparam int ADDR_HI    = 35;

   localparam int TIMER_W    = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      RDWAIT   = 3'd2,
      RPW_HOLD = 3'd3,
      DONE     = 3'd4
   } bus_state_t;

   // Builds the 36-bit bus address word: flags in [0:13], address in [14:35].
   function automatic logic [0:35] build_addr_word(
      input logic        rd,
      input logic        rpw,
      input logic        wr,
      input logic        io,
      input logic [14:35] addr
   );
      logic [0:35] word;
      word                   = 36'd0;
      word[FLAG_READ]        = rd;
      word[FLAG_RPW]         = rpw;
      word[FLAG_WRITE]       = wr;
      word[FLAG_IO]          = io;
      word[ADDR_LO:ADDR_HI]  = addr;
      return word;
   endfunction

endpackage

// File: rtl/mem_nxm_timer.sv
// Loadable saturating up-counter with clear and enable. tc is high during
// the LIMIT-th consecutive enabled cycle after a clear, i.e. the cycle in
// which the bound expires.
module mem_nxm_timer
   import mem_bus_pkg::*;
#(
   parameter int unsigned LIMIT = 15
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               en,
   output logic               tc
);

   localparam logic [TIMER_W-1:0] LIM = TIMER_W'(LIMIT);

   logic [TIMER_W-1:0] count;

   // Counter: clear has priority over load, load over increment; holds at LIM.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {TIMER_W{1'b0}};
      end else if (clr) begin
         count <= {TIMER_W{1'b0}};
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != LIM)) begin
         count <= count + TIMER_W'(1);
      end else begin
         count <= count;
      end
   end

   assign tc = (count >= (LIM - TIMER_W'(1)));

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the KS-10 memory/IO bus. Issues single read, write
// and read-pause-write cycles, waits for the responder acknowledge and
// reports non-existent memory when the acknowledge never arrives.
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned RPWHOLD = 255
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         cpuREQ,
   input  logic         cpuREAD,
   input  logic         cpuWRITE,
   input  logic         cpuIO,
   input  logic [14:35] cpuADDR,
   input  logic [0:35]  cpuWDATA,
   output logic [0:35]  cpuRDATA,
   output logic         cpuBUSY,
   output logic         cpuDONE,
   output logic         cpuNXM,
   output logic         busREQO,
   input  logic         busACKI,
   output logic [0:35]  busADDRO,
   output logic [0:35]  busDATAO,
   input  logic [0:35]  busDATAI
);

   bus_state_t state;
   bus_state_t next_state;

   logic         rd_flag;
   logic         rpw_flag;
   logic         wr_flag;
   logic         io_flag;
   logic [14:35] addr_latch;
   logic [0:35]  wdata_latch;
   logic [0:35]  rdata;

   logic         bus_req;
   logic         busy;
   logic         done;
   logic         nxm;

   logic         accept;
   logic         write_phase;
   logic         done_event;
   logic         nxm_event;

   logic         tmo_tc;
   logic         hold_tc;

   mem_nxm_timer #(.LIMIT(TIMEOUT)) u_tmo_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (state != REQ),
      .load     (1'b0),
      .load_val ({TIMER_W{1'b0}}),
      .en       (state == REQ),
      .tc       (tmo_tc)
   );

   mem_nxm_timer #(.LIMIT(RPWHOLD)) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (state != RPW_HOLD),
      .load     (1'b0),
      .load_val ({TIMER_W{1'b0}}),
      .en       (state == RPW_HOLD),
      .tc       (hold_tc)
   );

   // Next-state decode; an acknowledge wins over a simultaneous timeout.
   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      write_phase = 1'b0;
      done_event  = 1'b0;
      nxm_event   = 1'b0;
      case (state)
         IDLE: begin
            if (cpuREQ && (cpuREAD || cpuWRITE)) begin
               next_state = REQ;
               accept     = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         REQ: begin
            if (busACKI) begin
               if (rd_flag) begin
                  next_state = RDWAIT;
               end else begin
                  next_state = DONE;
                  done_event = 1'b1;
               end
            end else if (tmo_tc) begin
               next_state = IDLE;
               nxm_event  = 1'b1;
            end else begin
               next_state = REQ;
            end
         end
         RDWAIT: begin
            done_event = 1'b1;
            if (rpw_flag) begin
               next_state = RPW_HOLD;
            end else begin
               next_state = DONE;
            end
         end
         RPW_HOLD: begin
            if (cpuREQ && cpuWRITE) begin
               next_state  = REQ;
               write_phase = 1'b1;
            end else if (hold_tc) begin
               next_state = IDLE;
               nxm_event  = 1'b1;
            end else begin
               next_state = RPW_HOLD;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Request capture; the RPW write phase swaps the read flag for the write flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_flag     <= 1'b0;
         rpw_flag    <= 1'b0;
         wr_flag     <= 1'b0;
         io_flag     <= 1'b0;
         addr_latch  <= 22'd0;
         wdata_latch <= 36'd0;
      end else if (accept) begin
         rd_flag     <= cpuREAD;
         rpw_flag    <= cpuREAD & cpuWRITE;
         wr_flag     <= cpuWRITE & ~cpuREAD;
         io_flag     <= cpuIO;
         addr_latch  <= cpuADDR;
         wdata_latch <= cpuWDATA;
      end else if (write_phase) begin
         rd_flag     <= 1'b0;
         wr_flag     <= 1'b1;
         wdata_latch <= cpuWDATA;
      end else begin
         rd_flag     <= rd_flag;
         wr_flag     <= wr_flag;
         wdata_latch <= wdata_latch;
      end
   end

   // Read data register, loaded at the end of the read-latency cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= 36'd0;
      end else if (state == RDWAIT) begin
         rdata <= busDATAI;
      end else begin
         rdata <= rdata;
      end
   end

   // Registered handshake outputs, decoded from the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         nxm     <= 1'b0;
      end else begin
         bus_req <= (next_state == REQ);
         busy    <= (next_state != IDLE);
         done    <= done_event;
         nxm     <= nxm_event;
      end
   end

   assign busREQO  = bus_req;
   assign busADDRO = build_addr_word(rd_flag, rpw_flag, wr_flag, io_flag, addr_latch);
   assign busDATAO = wdata_latch;
   assign cpuRDATA = rdata;
   assign cpuBUSY  = busy;
   assign cpuDONE  = done;
   assign cpuNXM   = nxm;

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomised self-checking bench for mem_bus_master. The bench plays the
// responder (programmable acknowledge delay, one-cycle read latency, backing
// memory) and predicts outcomes from the bus protocol rules.
module tb_mem_bus_master;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpuREQ, cpuREAD, cpuWRITE, cpuIO;
   logic [14:35] cpuADDR;
   logic [0:35]  cpuWDATA;
   logic [0:35]  cpuRDATA;
   logic         cpuBUSY, cpuDONE, cpuNXM;
   logic         busREQO, busACKI;
   logic [0:35]  busADDRO, busDATAO, busDATAI;

   int errors = 0;
   int checks = 0;

   // responder / observation state
   int          ack_delay;
   bit          spam_req;
   int          obs_req, obs_acks, obs_done_at, obs_done_count, obs_nxm_at, obs_nxm_count, req_run;
   logic [35:0] obs_word, obs_data, obs_rdata_done;
   bit          prev_ack_read;
   logic [21:0] ack_addr;
   logic [35:0] mem [logic [21:0]];
   logic [35:0] last_rdata;

   mem_bus_master #(.TIMEOUT(15), .RPWHOLD(255)) dut (
      .clk(clk), .rst(rst),
      .cpuREQ(cpuREQ), .cpuREAD(cpuREAD), .cpuWRITE(cpuWRITE), .cpuIO(cpuIO),
      .cpuADDR(cpuADDR), .cpuWDATA(cpuWDATA), .cpuRDATA(cpuRDATA),
      .cpuBUSY(cpuBUSY), .cpuDONE(cpuDONE), .cpuNXM(cpuNXM),
      .busREQO(busREQO), .busACKI(busACKI), .busADDRO(busADDRO),
      .busDATAO(busDATAO), .busDATAI(busDATAI)
   );

   always #5 clk = ~clk;

   // Expected address word: bit n of the [0:35] word weighs 2**(35-n).
   function automatic logic [35:0] exp_word(input bit rd, input bit rpw, input bit wr,
                                            input bit io, input logic [21:0] a);
      logic [35:0] w;
      w = {14'd0, a};
      if (rd)  w = w + (36'd1 << 32);
      if (rpw) w = w + (36'd1 << 31);
      if (wr)  w = w + (36'd1 << 30);
      if (io)  w = w + (36'd1 << 25);
      return w;
   endfunction

   function automatic logic [35:0] rand36();
      return {4'($urandom_range(0, 15)), 32'($urandom())};
   endfunction

   // Present a request; must be called at a falling edge.
   task automatic start_req(input bit rd, input bit wr, input bit io,
                            input logic [21:0] a, input logic [35:0] d);
      cpuREQ   = 1'b1;
      cpuREAD  = rd;
      cpuWRITE = wr;
      cpuIO    = io;
      cpuADDR  = a;
      cpuWDATA = d;
   endtask

   // Run up to max_cycles falling edges acting as responder and recording events.
   task automatic watch(input int max_cycles, input bit stop_on_done);
      obs_req = 0; obs_acks = 0; obs_done_at = 0; obs_done_count = 0;
      obs_nxm_at = 0; obs_nxm_count = 0; req_run = 0;
      obs_word = 36'd0; obs_data = 36'd0; obs_rdata_done = 36'd0;
      prev_ack_read = 1'b0;
      for (int c = 1; c <= max_cycles; c++) begin
         @(negedge clk);
         if (cpuDONE) begin
            obs_done_count++;
            if (obs_done_at == 0) begin
               obs_done_at    = c;
               obs_rdata_done = cpuRDATA;
            end
         end
         if (cpuNXM) begin
            obs_nxm_count++;
            if (obs_nxm_at == 0) obs_nxm_at = c;
         end
         cpuADDR  = 22'($urandom());
         cpuWDATA = rand36();
         cpuIO    = 1'($urandom_range(0, 1));
         cpuREAD  = 1'($urandom_range(0, 1));
         if (spam_req && cpuBUSY) begin
            cpuREQ   = 1'b1;
            cpuWRITE = 1'b1;
         end else begin
            cpuREQ   = 1'b0;
            cpuWRITE = 1'($urandom_range(0, 1));
         end
         if (prev_ack_read) busDATAI = mem[ack_addr];
         else               busDATAI = rand36();
         prev_ack_read = 1'b0;
         if (busREQO) begin
            if (ack_delay >= 0 && req_run == ack_delay) begin
               busACKI  = 1'b1;
               obs_acks++;
               obs_word = busADDRO;
               obs_data = busDATAO;
               ack_addr = busADDRO[14:35];
               if (busADDRO[5]) mem[ack_addr] = busDATAO;
               else if (!mem.exists(ack_addr)) mem[ack_addr] = rand36();
               prev_ack_read = busADDRO[3];
            end else begin
               busACKI = 1'b0;
            end
            req_run++;
            obs_req++;
         end else begin
            busACKI = 1'b0;
            req_run = 0;
         end
         if (stop_on_done && cpuDONE) break;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (busREQO !== 1'b0)   begin errors++; $display("FAIL reset_busreqo: got %b expected 0", busREQO); end
      checks++; if (busADDRO !== 36'd0) begin errors++; $display("FAIL reset_busaddro: got %o expected 0", busADDRO); end
      checks++; if (busDATAO !== 36'd0) begin errors++; $display("FAIL reset_busdatao: got %o expected 0", busDATAO); end
      checks++; if (cpuRDATA !== 36'd0) begin errors++; $display("FAIL reset_rdata: got %o expected 0", cpuRDATA); end
      checks++; if ({cpuBUSY, cpuDONE, cpuNXM} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {cpuBUSY, cpuDONE, cpuNXM}); end
      rst = 1'b0;
      last_rdata = 36'd0;
   endtask

   task automatic test_write();
      logic [21:0] a = 22'o001000;
      logic [35:0] d = 36'o123456701234;
      ack_delay = 0;
      start_req(1'b0, 1'b1, 1'b0, a, d);
      watch(12, 1'b0);
      checks++; if (obs_word !== exp_word(0, 0, 1, 0, a)) begin errors++; $display("FAIL write_addr: got %o expected %o", obs_word, exp_word(0, 0, 1, 0, a)); end
      checks++; if (obs_data !== d) begin errors++; $display("FAIL write_data: got %o expected %o", obs_data, d); end
      checks++; if (obs_req != 1) begin errors++; $display("FAIL write_req_cycles: got %0d expected 1", obs_req); end
      checks++; if (obs_done_at != 2 || obs_done_count != 1) begin errors++; $display("FAIL write_done: at %0d count %0d expected at 2 count 1", obs_done_at, obs_done_count); end
      checks++; if (obs_nxm_count != 0 || cpuBUSY !== 1'b0) begin errors++; $display("FAIL write_end: nxm %0d busy %b expected 0 0", obs_nxm_count, cpuBUSY); end
   endtask

   task automatic test_read();
      logic [21:0] a = 22'o002000;
      mem[a] = 36'o777000111222;
      ack_delay = 0;
      start_req(1'b1, 1'b0, 1'b0, a, rand36());
      watch(12, 1'b0);
      checks++; if (obs_word !== exp_word(1, 0, 0, 0, a)) begin errors++; $display("FAIL read_addr: got %o expected %o", obs_word, exp_word(1, 0, 0, 0, a)); end
      checks++; if (obs_done_at != 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", obs_done_at); end
      checks++; if (obs_rdata_done !== 36'o777000111222) begin errors++; $display("FAIL read_data: got %o expected 777000111222", obs_rdata_done); end
      checks++; if (cpuRDATA !== 36'o777000111222) begin errors++; $display("FAIL read_hold: got %o expected 777000111222", cpuRDATA); end
      last_rdata = 36'o777000111222;
   endtask

   task automatic test_nxm();
      ack_delay = -1;
      start_req(1'b1, 1'b0, 1'b0, 22'o100000, rand36());
      watch(30, 1'b0);
      checks++; if (obs_req != 15) begin errors++; $display("FAIL nxm_req_cycles: got %0d expected 15", obs_req); end
      checks++; if (obs_nxm_count != 1 || obs_nxm_at != 16) begin errors++; $display("FAIL nxm_pulse: count %0d at %0d expected 1 at 16", obs_nxm_count, obs_nxm_at); end
      checks++; if (obs_done_count != 0) begin errors++; $display("FAIL nxm_no_done: got %0d expected 0", obs_done_count); end
      checks++; if (cpuRDATA !== last_rdata) begin errors++; $display("FAIL nxm_rdata: got %o expected %o", cpuRDATA, last_rdata); end
   endtask

   task automatic test_rpw();
      logic [21:0] a = 22'o000100;
      logic [35:0] v = rand36();
      mem[a] = v;
      ack_delay = 0;
      start_req(1'b1, 1'b1, 1'b0, a, rand36());
      watch(12, 1'b1);
      checks++; if (obs_word !== exp_word(1, 1, 0, 0, a)) begin errors++; $display("FAIL rpw_read_addr: got %o expected %o", obs_word, exp_word(1, 1, 0, 0, a)); end
      checks++; if (obs_done_at != 3 || obs_rdata_done !== v) begin errors++; $display("FAIL rpw_read_done: at %0d data %o expected at 3 data %o", obs_done_at, obs_rdata_done, v); end
      checks++; if (cpuBUSY !== 1'b1) begin errors++; $display("FAIL rpw_hold_busy: got %b expected 1", cpuBUSY); end
      last_rdata = v;
      @(negedge clk);
      start_req(1'b0, 1'b1, 1'b0, 22'($urandom()), 36'o000000000001);
      watch(12, 1'b0);
      checks++; if (obs_word !== exp_word(0, 1, 1, 0, a)) begin errors++; $display("FAIL rpw_write_addr: got %o expected %o", obs_word, exp_word(0, 1, 1, 0, a)); end
      checks++; if (obs_data !== 36'o000000000001) begin errors++; $display("FAIL rpw_write_data: got %o expected 1", obs_data); end
      checks++; if (obs_done_at != 2 || obs_done_count != 1 || cpuBUSY !== 1'b0) begin errors++; $display("FAIL rpw_write_done: at %0d count %0d busy %b expected 2 1 0", obs_done_at, obs_done_count, cpuBUSY); end
      checks++; if (cpuRDATA !== v) begin errors++; $display("FAIL rpw_rdata_hold: got %o expected %o", cpuRDATA, v); end
   endtask

   task automatic test_busy();
      logic [21:0] a = 22'($urandom());
      logic [35:0] d = rand36();
      ack_delay = 3;
      spam_req  = 1'b1;
      start_req(1'b0, 1'b1, 1'b0, a, d);
      watch(20, 1'b0);
      spam_req  = 1'b0;
      checks++; if (obs_acks != 1 || obs_req != 4) begin errors++; $display("FAIL busy_single_cycle: acks %0d req %0d expected 1 4", obs_acks, obs_req); end
      checks++; if (obs_word !== exp_word(0, 0, 1, 0, a) || obs_data !== d) begin errors++; $display("FAIL busy_latched: addr %o data %o expected %o %o", obs_word, obs_data, exp_word(0, 0, 1, 0, a), d); end
      checks++; if (obs_done_count != 1 || obs_done_at != 5) begin errors++; $display("FAIL busy_done: count %0d at %0d expected 1 at 5", obs_done_count, obs_done_at); end
   endtask

   task automatic test_back_to_back();
      logic [21:0] a2 = 22'($urandom());
      logic [35:0] d2 = rand36();
      ack_delay = 0;
      start_req(1'b0, 1'b1, 1'b0, 22'($urandom()), rand36());
      watch(12, 1'b1);
      start_req(1'b0, 1'b1, 1'b0, a2, d2);
      @(negedge clk);
      checks++; if (busREQO !== 1'b0 || cpuBUSY !== 1'b0) begin errors++; $display("FAIL b2b_ignored_in_done: busreqo %b busy %b expected 0 0", busREQO, cpuBUSY); end
      watch(12, 1'b0);
      checks++; if (obs_acks != 1 || obs_done_at != 2) begin errors++; $display("FAIL b2b_next_accept: acks %0d done_at %0d expected 1 2", obs_acks, obs_done_at); end
      checks++; if (obs_word !== exp_word(0, 0, 1, 0, a2) || obs_data !== d2) begin errors++; $display("FAIL b2b_addr_data: %o %o expected %o %o", obs_word, obs_data, exp_word(0, 0, 1, 0, a2), d2); end
   endtask

   task automatic test_reset_mid();
      ack_delay = -1;
      start_req(1'b1, 1'b0, 1'b0, 22'($urandom()), rand36());
      watch(4, 1'b0);
      checks++; if (busREQO !== 1'b1) begin errors++; $display("FAIL rstmid_in_req: got %b expected 1", busREQO); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({busREQO, cpuBUSY, cpuDONE, cpuNXM} !== 4'b0000) begin errors++; $display("FAIL rstmid_outputs: got %b expected 0000", {busREQO, cpuBUSY, cpuDONE, cpuNXM}); end
      checks++; if (cpuRDATA !== 36'd0) begin errors++; $display("FAIL rstmid_rdata: got %o expected 0", cpuRDATA); end
      rst = 1'b0;
      last_rdata = 36'd0;
      watch(25, 1'b0);
      checks++; if (obs_req != 0 || obs_done_count != 0 || obs_nxm_count != 0) begin errors++; $display("FAIL rstmid_quiet: req %0d done %0d nxm %0d expected 0 0 0", obs_req, obs_done_count, obs_nxm_count); end
   endtask

   task automatic test_ack_on_timeout();
      logic [21:0] a = 22'($urandom());
      ack_delay = 14;
      start_req(1'b0, 1'b1, 1'b1, a, rand36());
      watch(30, 1'b0);
      checks++; if (obs_req != 15 || obs_acks != 1) begin errors++; $display("FAIL late_ack_cycles: req %0d acks %0d expected 15 1", obs_req, obs_acks); end
      checks++; if (obs_nxm_count != 0 || obs_done_count != 1 || obs_done_at != 16) begin errors++; $display("FAIL late_ack_result: nxm %0d done %0d at %0d expected 0 1 16", obs_nxm_count, obs_done_count, obs_done_at); end
      checks++; if (obs_word !== exp_word(0, 0, 1, 1, a)) begin errors++; $display("FAIL late_ack_io_addr: got %o expected %o", obs_word, exp_word(0, 0, 1, 1, a)); end
   endtask

   task automatic test_rpw_hold_timeout();
      logic [21:0] a = 22'($urandom());
      ack_delay = 0;
      start_req(1'b1, 1'b1, 1'b1, a, rand36());
      watch(12, 1'b1);
      last_rdata = obs_rdata_done;
      checks++; if (busADDRO !== exp_word(1, 1, 0, 1, a)) begin errors++; $display("FAIL hold_addr: got %o expected %o", busADDRO, exp_word(1, 1, 0, 1, a)); end
      watch(300, 1'b0);
      checks++; if (obs_nxm_at != 255 || obs_nxm_count != 1) begin errors++; $display("FAIL hold_nxm: at %0d count %0d expected 255 1", obs_nxm_at, obs_nxm_count); end
      checks++; if (obs_req != 0 || obs_done_count != 0 || cpuBUSY !== 1'b0) begin errors++; $display("FAIL hold_end: req %0d done %0d busy %b expected 0 0 0", obs_req, obs_done_count, cpuBUSY); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         bit          rd = 1'($urandom_range(0, 1));
         bit          io = 1'($urandom_range(0, 1));
         logic [21:0] a  = 22'o010000 + 22'($urandom_range(0, 7));
         logic [35:0] d  = rand36();
         ack_delay = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 6));
         start_req(rd, !rd, io, a, d);
         watch(25, 1'b0);
         if (ack_delay < 0) begin
            checks++; if (obs_req != 15 || obs_nxm_at != 16 || obs_done_count != 0) begin errors++; $display("FAIL rand_nxm[%0d]: req %0d nxm_at %0d done %0d expected 15 16 0", i, obs_req, obs_nxm_at, obs_done_count); end
            checks++; if (cpuRDATA !== last_rdata) begin errors++; $display("FAIL rand_nxm_rdata[%0d]: got %o expected %o", i, cpuRDATA, last_rdata); end
         end else begin
            checks++; if (obs_req != ack_delay + 1 || obs_done_at != ack_delay + 2 + int'(rd)) begin errors++; $display("FAIL rand_timing[%0d]: req %0d done_at %0d expected %0d %0d", i, obs_req, obs_done_at, ack_delay + 1, ack_delay + 2 + int'(rd)); end
            checks++; if (obs_word !== exp_word(rd, 0, !rd, io, a)) begin errors++; $display("FAIL rand_addr[%0d]: got %o expected %o", i, obs_word, exp_word(rd, 0, !rd, io, a)); end
            if (rd) begin
               checks++; if (obs_rdata_done !== mem[a]) begin errors++; $display("FAIL rand_rdata[%0d]: got %o expected %o", i, obs_rdata_done, mem[a]); end
               last_rdata = mem[a];
            end else begin
               checks++; if (obs_data !== d || cpuRDATA !== last_rdata) begin errors++; $display("FAIL rand_write[%0d]: data %o rdata %o expected %o %o", i, obs_data, cpuRDATA, d, last_rdata); end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      cpuREQ = 1'b0; cpuREAD = 1'b0; cpuWRITE = 1'b0; cpuIO = 1'b0;
      cpuADDR = 22'd0; cpuWDATA = 36'd0;
      busACKI = 1'b0; busDATAI = 36'd0;
      spam_req = 1'b0; ack_delay = 0; last_rdata = 36'd0;
      test_reset();
      test_write();
      test_read();
      test_nxm();
      test_rpw();
      test_busy();
      test_back_to_back();
      test_reset_mid();
      test_ack_on_timeout();
      test_rpw_hold_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the KS-10 memory/IO bus; the requesting end of the same request/acknowledge protocol the memory responder implements.
- Accepts single read, write and read-pause-write (RPW) requests from the microcode/CPU datapath.
- Drives busREQO, the flag-encoded address word and the write data, then waits for busACKI.
- Returns read data, or reports non-existent memory (NXM) when no acknowledge arrives within a timeout.

Parameters:
- TIMEOUT, 15: cycles busREQO may stay high without busACKI before NXM is declared (1..255).
- RPWHOLD, 255: maximum cycles held between the read and write phases of an RPW before the cycle is abandoned as NXM.

Ports:
- clk  input  1  Clock; all logic on rising edge.
- rst  input  1  Synchronous reset, active-high.
- cpuREQ  input  1  Request strobe; sampled only when cpuBUSY=0, or in RPW_HOLD.
- cpuREAD  input  1  Read cycle.
- cpuWRITE  input  1  Write cycle (cpuREAD&cpuWRITE = RPW).
- cpuIO  input  1  IO-space cycle.
- cpuADDR  input  [14:35]  Physical address.
- cpuWDATA  input  [0:35]  Write data.
- cpuRDATA  output  [0:35]  Last read data, held until next read completes.
- cpuBUSY  output  1  Cycle in progress.
- cpuDONE  output  1  One-cycle completion pulse.
- cpuNXM  output  1  One-cycle timeout pulse.
- busREQO  output  1  Bus request.
- busACKI  input  1  Responder acknowledge (may be combinational on busADDRO).
- busADDRO  output  [0:35]  Flags [0:13] plus address [14:35].
- busDATAO  output  [0:35]  Write data to responder.
- busDATAI  input  [0:35]  Read data from responder.

Behaviour:
- Flag encoding of busADDRO:
  - Bit 3 = read; bit 4 = RPW; bit 5 = write; bit 10 = IO.
  - All other flag bits are 0.
  - Bits 14:35 = latched cpuADDR.
- Request capture: on an accepted request, cpuADDR, the flags and cpuWDATA are registered. busADDRO/busDATAO stay stable while busREQO=1.
- Reset values: busREQO=0, busADDRO=0, busDATAO=0, cpuRDATA=0, cpuBUSY=0, cpuDONE=0, cpuNXM=0, state IDLE, timer 0.
- IDLE:
  - On cpuREQ with READ|WRITE set, latch the request and go to REQ; cpuBUSY=1 from the next cycle.
  - cpuREQ with neither flag set is ignored.
- REQ:
  - busREQO=1; timer increments each cycle.
  - If busACKI=1 and the cycle is a write: go to DONE.
  - If busACKI=1 and the cycle is a read or RPW: go to RDWAIT.
  - If timer reaches TIMEOUT with no busACKI: busREQO drops, cpuNXM pulses, return to IDLE. cpuRDATA is unchanged.
  - busACKI arriving on the same cycle the timer expires counts as an acknowledge, not NXM.
- RDWAIT:
  - busREQO=0.
  - busDATAI is captured into cpuRDATA at the end of this cycle (one-cycle responder read latency).
  - Plain read: go to DONE. RPW: pulse cpuDONE and go to RPW_HOLD.
- RPW_HOLD:
  - cpuBUSY=1; bit 4 stays set in busADDRO; the address is held.
  - cpuREQ with cpuWRITE: latch cpuWDATA, clear the read flag, set the write flag, go to REQ.
  - Hold counter reaching RPWHOLD: cpuNXM pulses, go to IDLE.
- DONE: single cycle; cpuDONE=1, busREQO=0; go to IDLE with cpuBUSY=0 the following cycle.
- Latency:
  - Write with immediate acknowledge: 2 cycles from accept to cpuDONE.
  - Read with immediate acknowledge: 3 cycles.
- Back-to-back: a cpuREQ in the cycle cpuDONE is high is ignored; a new request may be accepted the following cycle.
- Reset mid-operation: rst on any edge returns to IDLE, drops busREQO and clears the pulses. cpuRDATA is reset to 0 and no partial write is retried.

Decomposition:
- Package mem_bus_pkg:
  - Flag bit indices: READ=3, RPW=4, WRITE=5, IO=10.
  - Address field bounds 14:35.
  - State enumeration: IDLE, REQ, RDWAIT, RPW_HOLD, DONE.
- One sub-module, mem_nxm_timer: a loadable saturating counter with clear, enable and terminal-count output, parameterized by limit. It is instantiated twice, for TIMEOUT and RPWHOLD.

Test Plan:
1. Write, ack immediate: cpuREQ+WRITE, addr 0o001000, data 0o123456701234 -> busADDRO flags bit5 only, busREQO 1 cycle, cpuDONE 2 cycles after accept, busDATAO matches.
2. Read, ack immediate: responder returns 0o777000111222 one cycle after ack -> cpuRDATA=0o777000111222 with cpuDONE at cycle 3; bit3 set, bit5 clear.
3. NXM: address 0o100000 with busACKI held 0, TIMEOUT=15 -> busREQO high exactly 15 cycles, cpuNXM one pulse, cpuDONE never, cpuRDATA unchanged.
4. RPW: READ+WRITE at 0o000100 -> read phase shows bits 3,4 set; cpuDONE with read data; second cpuREQ+WRITE with 0o000000000001 -> bits 4,5 set, same address, second cpuDONE.
5. Busy/reset: cpuREQ pulses while cpuBUSY=1 are ignored (exactly one bus cycle observed); rst asserted during REQ -> next cycle busREQO=0, cpuBUSY=0, and no cpuDONE or cpuNXM.
6. Edge cases: busACKI first asserted on the timeout cycle -> treated as acknowledge; RPW_HOLD left idle for RPWHOLD cycles -> cpuNXM and return to IDLE.
